// File: rtl/rst_seq.sv
// Reset sequencer: holds mem/periph/core domains in reset on any request, then releases them in order.
// Latency: mem released HOLD_CYCLES edges after the last request edge, periph STAGE_GAP later, core STAGE_GAP after that.
// Backpressure: none; a new request at any time restarts the sequence from ASSERT with the counter cleared.
module rst_seq #(
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ndmreset_i,
  input  logic       prog_rst_req_i,
  input  logic       wdt_rst_req_i,
  input  logic       sw_rst_req_i,
  input  logic       cause_clr_i,
  output logic       mem_rst_no,
  output logic       periph_rst_no,
  output logic       core_rst_no,
  output logic       busy_o,
  output logic [4:0] rst_cause_o
);

  // One shared counter covers both the hold phase and each stage gap.
  localparam int MAX_CNT = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);

  typedef enum logic [1:0] {
    ASSERT       = 2'd0,
    STAGE_MEM    = 2'd1,
    STAGE_PERIPH = 2'd2,
    IDLE         = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          req;
  logic [4:0]    cause_set;

  assign req       = ndmreset_i | prog_rst_req_i | wdt_rst_req_i | sw_rst_req_i;
  assign cause_set = {sw_rst_req_i, wdt_rst_req_i, prog_rst_req_i, ndmreset_i, 1'b0};

  // Next-state and counter: any request pins the sequence at ASSERT with the counter at 0.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (req) begin
      state_nxt = ASSERT;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ASSERT: begin
          if (cnt == HOLD_LAST) begin
            state_nxt = STAGE_MEM;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        STAGE_MEM: begin
          if (cnt == GAP_LAST) begin
            state_nxt = STAGE_PERIPH;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        STAGE_PERIPH: begin
          if (cnt == GAP_LAST) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        IDLE: begin
          cnt_nxt = '0;
        end
        default: begin
          state_nxt = ASSERT;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State, counter and flopped domain resets; outputs decode the next state so they change on the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= ASSERT;
      cnt           <= '0;
      mem_rst_no    <= 1'b0;
      periph_rst_no <= 1'b0;
      core_rst_no   <= 1'b0;
      busy_o        <= 1'b1;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      mem_rst_no    <= (state_nxt != ASSERT);
      periph_rst_no <= (state_nxt == STAGE_PERIPH) || (state_nxt == IDLE);
      core_rst_no   <= (state_nxt == IDLE);
      busy_o        <= (state_nxt != IDLE);
    end
  end

  // Sticky cause register; a request seen in the same cycle as a clear survives the clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rst_cause_o <= 5'b00001;
    end else if (cause_clr_i) begin
      rst_cause_o <= cause_set;
    end else begin
      rst_cause_o <= rst_cause_o | cause_set;
    end
  end

endmodule

// File: tb/tb_rst_seq.sv
// Testbench for rst_seq: directed scenarios plus randomized requests, scoreboarded against a time-since-request model.
// Latency: expected outputs are checked one falling edge after the rising edge they belong to.
// Backpressure: not applicable; the monitor drains one expected entry per cycle.
module tb_rst_seq;

  localparam int H = 16;
  localparam int G = 4;

  logic       clk;
  logic       rst;
  logic       ndm;
  logic       prog;
  logic       wdt;
  logic       sw;
  logic       clr;
  logic       mem_n;
  logic       periph_n;
  logic       core_n;
  logic       busy;
  logic [4:0] cause;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       mem_n;
    logic       periph_n;
    logic       core_n;
    logic       busy;
    logic [4:0] cause;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: cycles elapsed since the last edge that saw rst or any request.
  int         m_t     = 0;
  logic [4:0] m_cause = 5'b00001;

  rst_seq #(.HOLD_CYCLES(H), .STAGE_GAP(G)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ndmreset_i     (ndm),
    .prog_rst_req_i (prog),
    .wdt_rst_req_i  (wdt),
    .sw_rst_req_i   (sw),
    .cause_clr_i    (clr),
    .mem_rst_no     (mem_n),
    .periph_rst_no  (periph_n),
    .core_rst_no    (core_n),
    .busy_o         (busy),
    .rst_cause_o    (cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs for the next rising edge and queue the outputs the model predicts after it.
  task automatic step(input logic r, input logic n, input logic p,
                      input logic w, input logic s, input logic c);
    exp_t       e;
    logic [4:0] set;
    @(negedge clk);
    #1;
    rst = r; ndm = n; prog = p; wdt = w; sw = s; clr = c;
    if (r) begin
      m_t     = 0;
      m_cause = 5'b00001;
    end else begin
      if (n | p | w | s) m_t = 0;
      else if (m_t < 1000) m_t = m_t + 1;
      set     = {s, w, p, n, 1'b0};
      m_cause = c ? set : (m_cause | set);
    end
    e.mem_n    = (m_t >= H);
    e.periph_n = (m_t >= H + G);
    e.core_n   = (m_t >= H + 2 * G);
    e.busy     = (m_t < H + 2 * G);
    e.cause    = m_cause;
    exp_q.push_back(e);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compares DUT outputs mid-cycle whenever a prediction is pending.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({mem_n, periph_n, core_n} !== {e.mem_n, e.periph_n, e.core_n}) begin
          errors++;
          $display("FAIL resets t=%0t got=%b exp=%b", $time,
                   {mem_n, periph_n, core_n}, {e.mem_n, e.periph_n, e.core_n});
        end
        checks++;
        if (busy !== e.busy) begin
          errors++;
          $display("FAIL busy t=%0t got=%b exp=%b", $time, busy, e.busy);
        end
        checks++;
        if (cause !== e.cause) begin
          errors++;
          $display("FAIL cause t=%0t got=%b exp=%b", $time, cause, e.cause);
        end
      end
    end
  end

  // Stimulus: directed scenarios first, then randomized traffic.
  initial begin
    int ndm_hold;
    logic r, n, p, w, s, c;
    rst = 1'b1; ndm = 1'b0; prog = 1'b0; wdt = 1'b0; sw = 1'b0; clr = 1'b0;

    // Power-on reset for three edges, then a full release sequence into IDLE.
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    quiet(30);

    // Watchdog single-cycle pulse from IDLE.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    quiet(30);

    // Non-debug reset held as a level for ten edges.
    repeat (10) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    quiet(30);

    // Software pulse landing in STAGE_PERIPH with counter at 2.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    quiet(22);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    quiet(30);

    // Cause clear racing a programming request, from cause 01001.
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    quiet(28);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    quiet(30);

    // rst pulse while in STAGE_MEM, with requests and clear also asserted.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    quiet(17);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    quiet(30);

    // Randomized traffic: sparse pulses, occasional held ndm, rare rst, frequent clears.
    ndm_hold = 0;
    for (int i = 0; i < 2500; i++) begin
      if (ndm_hold == 0 && $urandom_range(0, 99) == 0) ndm_hold = $urandom_range(1, 12);
      n = (ndm_hold > 0);
      if (ndm_hold > 0) ndm_hold--;
      r = ($urandom_range(0, 299) == 0);
      p = ($urandom_range(0, 79) == 0);
      w = ($urandom_range(0, 79) == 0);
      s = ($urandom_range(0, 79) == 0);
      c = ($urandom_range(0, 14) == 0);
      step(r, n, p, w, s, c);
    end
    quiet(30);

    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
